mc_control_fsm: RTL and testbench

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects, the write enables and the 2-bit ALUOp consumed by ALU control, which in turn produces the 3-bit ALU operation code. Stalls on a memory ready handshake.

---
 rtl/mc_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/memory/writeback sequencing.
// Optional addi support is built when MC_ADDI_EN is defined.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t cur_state, nxt_state;

  // Write enables before reset gating
  logic pcw_raw, pcwc_raw, irw_raw, memw_raw, regw_raw, ill_raw;

  assign state = cur_state;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    nxt_state  = S_FETCH;
    pcw_raw    = 1'b0;
    pcwc_raw   = 1'b0;
    irw_raw    = 1'b0;
    memw_raw   = 1'b0;
    regw_raw   = 1'b0;
    ill_raw    = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    pc_source  = 2'b00;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_dst    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
        nxt_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt_state = S_ADDIEX;
`endif
          default: begin
            ill_raw   = 1'b1;
            nxt_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regw_raw   = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        memw_raw  = 1'b1;
        iord      = 1'b1;
        nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt_state = S_RWB;
      end
      S_RWB: begin
        regw_raw = 1'b1;
        reg_dst  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pcwc_raw  = 1'b1;
        pc_source = 2'b01;
      end
      S_JUMP: begin
        pcw_raw   = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regw_raw = 1'b1;
      end
`endif
      default: nxt_state = S_FETCH;
    endcase
  end

  // Reset abandons the current instruction: no architectural write may fire in that cycle
  assign pc_write      = pcw_raw  & ~rst;
  assign pc_write_cond = pcwc_raw & ~rst;
  assign ir_write      = irw_raw  & ~rst;
  assign mem_write     = memw_raw & ~rst;
  assign reg_write     = regw_raw & ~rst;
  assign illegal       = ill_raw  & ~rst;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: cycle-by-cycle vector table plus
// hand-written stall and instruction-length sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .illegal(illegal), .state(state)
  );

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
  //  pc_source[1:0], alu_op[1:0], alu_src_a, alu_src_b[1:0], reg_write, reg_dst, illegal}
  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
                     pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal};

  localparam logic [16:0] C_FETCH_GO   = {7'b1001001, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000};
  localparam logic [16:0] C_FETCH_WAIT = {7'b0001000, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000};
  localparam logic [16:0] C_DECODE     = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000};
  localparam logic [16:0] C_ILLEGAL    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b001};
  localparam logic [16:0] C_MEMADR     = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
  localparam logic [16:0] C_MEMRD      = {7'b0011000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [16:0] C_MEMWB      = {7'b0000010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100};
  localparam logic [16:0] C_MEMWR      = {7'b0010100, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [16:0] C_MEMWR_RST  = {7'b0010000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [16:0] C_EXEC       = {7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 3'b000};
  localparam logic [16:0] C_RWB        = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b110};
  localparam logic [16:0] C_RWB_RST    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b010};
  localparam logic [16:0] C_BRANCH     = {7'b0100000, 2'b01, 2'b01, 1'b1, 2'b00, 3'b000};
  localparam logic [16:0] C_JUMP       = {7'b1000000, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [16:0] C_JUMP_RST   = {7'b0000000, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
`ifdef MC_ADDI_EN
  localparam logic [16:0] C_ADDIEX     = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
  localparam logic [16:0] C_ADDIWB     = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100};
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctrl;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctrl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [16:0] cw);
    vec_t v;
    v.rst = r; v.opcode = op; v.mem_ready = mr; v.exp_state = st; v.exp_ctrl = cw;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge: drive, score at the falling edge, advance one edge.
  task automatic step(input string name, input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [16:0] cw);
    exp_t e;
    rst = r; opcode = op; mem_ready = mr;
    e.name = name; e.exp_state = st; e.exp_ctrl = cw;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, "_state"}, {28'd0, state}, {28'd0, e.exp_state});
    check({e.name, "_ctrl"}, {15'd0, act_ctrl}, {15'd0, e.exp_ctrl});
    @(posedge clk); #1;
  endtask

  // Runs one instruction with mem_ready=1 and returns how many edges until FETCH again.
  task automatic count_cycles(input logic [5:0] op, output int cycles);
    rst = 1'b0; opcode = op; mem_ready = 1'b1;
    cycles = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (state == 4'd0) break;
    end
  endtask

  initial begin
    int n_stall;
    int cyc;

    // Reset gating while already in FETCH, then R-type
    add(1, 6'h00, 1, 0, C_FETCH_WAIT);
    add(0, 6'h00, 1, 0, C_FETCH_GO);
    add(0, 6'h00, 1, 1, C_DECODE);
    add(0, 6'h00, 1, 6, C_EXEC);
    add(0, 6'h00, 1, 7, C_RWB);
    // lw with two MEMRD stall cycles
    add(0, 6'h23, 1, 0, C_FETCH_GO);
    add(0, 6'h23, 1, 1, C_DECODE);
    add(0, 6'h23, 1, 2, C_MEMADR);
    add(0, 6'h23, 0, 3, C_MEMRD);
    add(0, 6'h23, 0, 3, C_MEMRD);
    add(0, 6'h23, 1, 3, C_MEMRD);
    add(0, 6'h23, 1, 4, C_MEMWB);
    // sw, beq, j back-to-back
    add(0, 6'h2B, 1, 0, C_FETCH_GO);
    add(0, 6'h2B, 1, 1, C_DECODE);
    add(0, 6'h2B, 1, 2, C_MEMADR);
    add(0, 6'h2B, 1, 5, C_MEMWR);
    add(0, 6'h04, 1, 0, C_FETCH_GO);
    add(0, 6'h04, 1, 1, C_DECODE);
    add(0, 6'h04, 1, 8, C_BRANCH);
    add(0, 6'h02, 1, 0, C_FETCH_GO);
    add(0, 6'h02, 1, 1, C_DECODE);
    add(0, 6'h02, 1, 9, C_JUMP);
    // FETCH stall for three cycles, then R-type reset mid-EXEC for two cycles
    add(0, 6'h00, 0, 0, C_FETCH_WAIT);
    add(0, 6'h00, 0, 0, C_FETCH_WAIT);
    add(0, 6'h00, 0, 0, C_FETCH_WAIT);
    add(0, 6'h00, 1, 0, C_FETCH_GO);
    add(0, 6'h00, 1, 1, C_DECODE);
    add(1, 6'h00, 1, 6, C_EXEC);
    add(1, 6'h00, 1, 0, C_FETCH_WAIT);
    // Unsupported opcode, then addi
    add(0, 6'h3F, 1, 0, C_FETCH_GO);
    add(0, 6'h3F, 1, 1, C_ILLEGAL);
    add(0, 6'h08, 1, 0, C_FETCH_GO);
`ifdef MC_ADDI_EN
    add(0, 6'h08, 1, 1, C_DECODE);
    add(0, 6'h08, 1, 10, C_ADDIEX);
    add(0, 6'h08, 1, 11, C_ADDIWB);
`else
    add(0, 6'h08, 1, 1, C_ILLEGAL);
`endif
    // sw stall in MEMWR, reset while waiting gates mem_write
    add(0, 6'h2B, 1, 0, C_FETCH_GO);
    add(0, 6'h2B, 1, 1, C_DECODE);
    add(0, 6'h2B, 0, 2, C_MEMADR);
    add(0, 6'h2B, 0, 5, C_MEMWR);
    add(0, 6'h2B, 0, 5, C_MEMWR);
    add(1, 6'h2B, 0, 5, C_MEMWR_RST);
    // Reset in RWB and in JUMP gates reg_write / pc_write
    add(0, 6'h00, 1, 0, C_FETCH_GO);
    add(0, 6'h00, 1, 1, C_DECODE);
    add(0, 6'h00, 1, 6, C_EXEC);
    add(1, 6'h00, 1, 7, C_RWB_RST);
    add(0, 6'h02, 1, 0, C_FETCH_GO);
    add(0, 6'h02, 1, 1, C_DECODE);
    add(1, 6'h02, 1, 9, C_JUMP_RST);
    // mem_ready ignored outside FETCH/MEMRD/MEMWR
    add(0, 6'h00, 1, 0, C_FETCH_GO);
    add(0, 6'h00, 0, 1, C_DECODE);
    add(0, 6'h00, 0, 6, C_EXEC);
    add(0, 6'h00, 0, 7, C_RWB);

    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("v%0d", i), vecs[i].rst, vecs[i].opcode, vecs[i].mem_ready,
           vecs[i].exp_state, vecs[i].exp_ctrl);

    // lw with a random-length MEMRD stall
    n_stall = $urandom_range(1, 5);
    step("lw_f", 0, 6'h23, 1, 0, C_FETCH_GO);
    step("lw_d", 0, 6'h23, 1, 1, C_DECODE);
    step("lw_a", 0, 6'h23, 1, 2, C_MEMADR);
    for (int k = 0; k < n_stall; k++)
      step($sformatf("lw_wait%0d", k), 0, 6'h23, 0, 3, C_MEMRD);
    step("lw_rd", 0, 6'h23, 1, 3, C_MEMRD);
    step("lw_wb", 0, 6'h23, 1, 4, C_MEMWB);

    // Instruction lengths with mem_ready held high
    count_cycles(6'h00, cyc); check("rtype_cycles", cyc, 4);
    count_cycles(6'h23, cyc); check("lw_cycles", cyc, 5);
    count_cycles(6'h2B, cyc); check("sw_cycles", cyc, 4);
    count_cycles(6'h04, cyc); check("beq_cycles", cyc, 3);
    count_cycles(6'h02, cyc); check("j_cycles", cyc, 3);
    count_cycles(6'h3F, cyc); check("illegal_cycles", cyc, 2);
`ifdef MC_ADDI_EN
    count_cycles(6'h08, cyc); check("addi_cycles", cyc, 4);
`else
    count_cycles(6'h08, cyc); check("addi_cycles", cyc, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
